// File: rtl/branch_predictor_2bit.sv
// ---------------------------------------------------------------------------
// branch_predictor_2bit
//
// Direct-mapped table of 2-bit saturating counters, indexed by the low
// word-address bits of the PC. The IF stage looks up a prediction and gets a
// registered counter value one cycle later. The EX stage writes back resolved
// branch outcomes. Lookups and mispredictions are counted for performance
// measurement.
//
// Ports:
//   Clk            rising-edge clock
//   Reset          synchronous, active-low reset
//   LookupValid    IF requests a prediction this cycle
//   LookupPC       PC of the fetched instruction
//   PredState      registered counter value of the last accepted lookup
//   PredTaken      PredState[1], registered together with PredState
//   PredValid      high the cycle after an accepted lookup
//   UpdValid       EX resolves a branch this cycle
//   UpdPC          PC of the resolving branch
//   UpdTaken       resolved outcome (1 = taken)
//   UpdMispredict  EX detected a wrong prediction for this branch
//   LookupCount    accepted lookups since reset (saturating)
//   MispredCount   valid mispredicted updates since reset (saturating)
// ---------------------------------------------------------------------------
module branch_predictor_2bit #(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LookupValid,
    input  logic [31:0]      LookupPC,
    output logic [1:0]       PredState,
    output logic             PredTaken,
    output logic             PredValid,
    input  logic             UpdValid,
    input  logic [31:0]      UpdPC,
    input  logic             UpdTaken,
    input  logic             UpdMispredict,
    output logic [CNT_W-1:0] LookupCount,
    output logic [CNT_W-1:0] MispredCount
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic [1:0]          counter_table [DEPTH];
    logic [IDX_BITS-1:0] lookup_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic [1:0]          upd_old;
    logic [1:0]          upd_new;
    logic [1:0]          lookup_val;
    logic                unused_pc_bits;

    assign lookup_idx = LookupPC[IDX_BITS+1:2];
    assign upd_idx    = UpdPC[IDX_BITS+1:2];

    // Byte-offset and upper PC bits take no part in indexing; the table is
    // untagged so aliasing PCs deliberately share an entry.
    assign unused_pc_bits = ^{LookupPC[31:IDX_BITS+2], LookupPC[1:0],
                              UpdPC[31:IDX_BITS+2], UpdPC[1:0]};

    // Saturating increment/decrement of the entry being updated.
    always_comb begin
        upd_old = counter_table[upd_idx];
        upd_new = upd_old;
        if (UpdTaken) begin
            if (upd_old != 2'b11) begin
                upd_new = upd_old + 2'b01;
            end
        end else begin
            if (upd_old != 2'b00) begin
                upd_new = upd_old - 2'b01;
            end
        end
    end

    // Write-first bypass: a lookup hitting the entry being updated in the
    // same cycle sees the post-update value.
    always_comb begin
        lookup_val = counter_table[lookup_idx];
        if (UpdValid && (upd_idx == lookup_idx)) begin
            lookup_val = upd_new;
        end
    end

    // Counter table: reset to weakly not-taken; reset drops any update.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                counter_table[i] <= 2'b01;
            end
        end else if (UpdValid) begin
            counter_table[upd_idx] <= upd_new;
        end
    end

    // Prediction output register; state holds when no lookup is accepted.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            PredState <= 2'b01;
            PredTaken <= 1'b0;
            PredValid <= 1'b0;
        end else begin
            PredValid <= LookupValid;
            if (LookupValid) begin
                PredState <= lookup_val;
                PredTaken <= lookup_val[1];
            end
        end
    end

    // Statistics counters saturate at all-ones rather than wrapping.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            LookupCount  <= '0;
            MispredCount <= '0;
        end else begin
            if (LookupValid && (LookupCount != {CNT_W{1'b1}})) begin
                LookupCount <= LookupCount + 1'b1;
            end
            if (UpdValid && UpdMispredict && (MispredCount != {CNT_W{1'b1}})) begin
                MispredCount <= MispredCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_2bit
//
// Directed test of branch_predictor_2bit. Lookup expectations are queued when
// the stimulus edge happens and a monitor on the falling edge pops and checks
// them whenever PredValid is presented. A second instance with 2-bit
// statistics counters shares all inputs to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_branch_predictor_2bit;

    typedef struct {
        logic [1:0]  state;
        logic [15:0] lcnt;
        logic [15:0] mcnt;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic        LookupValid;
    logic [31:0] LookupPC;
    logic        UpdValid;
    logic [31:0] UpdPC;
    logic        UpdTaken;
    logic        UpdMispredict;

    logic [1:0]  pred_state;
    logic        pred_taken;
    logic        pred_valid;
    logic [15:0] lookup_count;
    logic [15:0] mispred_count;

    logic [1:0]  pred_state2;
    logic        pred_taken2;
    logic        pred_valid2;
    logic [1:0]  lookup_count2;
    logic [1:0]  mispred_count2;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    branch_predictor_2bit #(.IDX_BITS(6), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .LookupValid(LookupValid), .LookupPC(LookupPC),
        .PredState(pred_state), .PredTaken(pred_taken), .PredValid(pred_valid),
        .UpdValid(UpdValid), .UpdPC(UpdPC), .UpdTaken(UpdTaken),
        .UpdMispredict(UpdMispredict),
        .LookupCount(lookup_count), .MispredCount(mispred_count)
    );

    branch_predictor_2bit #(.IDX_BITS(6), .CNT_W(2)) dut_small (
        .Clk(Clk), .Reset(Reset),
        .LookupValid(LookupValid), .LookupPC(LookupPC),
        .PredState(pred_state2), .PredTaken(pred_taken2), .PredValid(pred_valid2),
        .UpdValid(UpdValid), .UpdPC(UpdPC), .UpdTaken(UpdTaken),
        .UpdMispredict(UpdMispredict),
        .LookupCount(lookup_count2), .MispredCount(mispred_count2)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // One directed comparison.
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs; an accepted lookup queues its expectation
    // right after the edge so the monitor sees it on the following negedge.
    task automatic applyStimulus(input logic rst, input logic lv, input logic [31:0] lpc,
                                 input logic uv, input logic [31:0] upc, input logic ut,
                                 input logic um, input logic [1:0] exp_state,
                                 input logic [15:0] exp_lcnt, input logic [15:0] exp_mcnt);
        exp_t e;
        Reset         = rst;
        LookupValid   = lv;
        LookupPC      = lpc;
        UpdValid      = uv;
        UpdPC         = upc;
        UpdTaken      = ut;
        UpdMispredict = um;
        @(posedge Clk);
        if (rst && lv) begin
            e.state = exp_state;
            e.lcnt  = exp_lcnt;
            e.mcnt  = exp_mcnt;
            sb_q.push_back(e);
        end
        #1;
    endtask

    task automatic doLookup(input logic [31:0] pc, input logic [1:0] st,
                            input logic [15:0] lc, input logic [15:0] mc);
        applyStimulus(1'b1, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, st, lc, mc);
    endtask

    task automatic doUpdate(input logic [31:0] pc, input logic taken, input logic misp);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, pc, taken, misp, 2'b00, 16'h0, 16'h0);
    endtask

    task automatic doIdle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    endtask

    // Scoreboard monitor: pops one expectation per presented prediction.
    always @(negedge Clk) begin
        exp_t e;
        if (pred_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_valid: got PredValid=1 expected no prediction");
            end else begin
                e = sb_q.pop_front();
                total++;
                if (pred_state !== e.state || pred_taken !== e.state[1]) begin
                    bad++;
                    $display("[TB] FAIL sb_pred: got state=%b taken=%b expected state=%b taken=%b",
                             pred_state, pred_taken, e.state, e.state[1]);
                end
                total++;
                if (lookup_count !== e.lcnt || mispred_count !== e.mcnt) begin
                    bad++;
                    $display("[TB] FAIL sb_counts: got lcnt=%0d mcnt=%0d expected lcnt=%0d mcnt=%0d",
                             lookup_count, mispred_count, e.lcnt, e.mcnt);
                end
            end
        end else if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL missing_valid: got PredValid=%b expected 1 (state %b)",
                     pred_valid, e.state);
        end
    end

    initial begin
        Reset = 1'b0;
        LookupValid = 1'b0;
        LookupPC = 32'h0;
        UpdValid = 1'b0;
        UpdPC = 32'h0;
        UpdTaken = 1'b0;
        UpdMispredict = 1'b0;

        // Reset for two cycles, then check reset state.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        checkOutput("rst_state", {14'h0, pred_state}, 16'h1);
        checkOutput("rst_taken", {15'h0, pred_taken}, 16'h0);
        checkOutput("rst_valid", {15'h0, pred_valid}, 16'h0);
        checkOutput("rst_lcnt", lookup_count, 16'h0);
        checkOutput("rst_mcnt", mispred_count, 16'h0);

        // First lookup after reset.
        doLookup(32'h40, 2'b01, 16'd1, 16'd0);

        // Saturate taken.
        repeat (4) doUpdate(32'h40, 1'b1, 1'b0);
        doLookup(32'h40, 2'b11, 16'd2, 16'd0);
        doUpdate(32'h40, 1'b1, 1'b0);
        doLookup(32'h40, 2'b11, 16'd3, 16'd0);
        doIdle();
        checkOutput("small_lcnt_at3", {14'h0, lookup_count2}, 16'd3);

        // Not-taken walk down with hysteresis.
        doUpdate(32'h40, 1'b0, 1'b0);
        doLookup(32'h40, 2'b10, 16'd4, 16'd0);
        repeat (3) doUpdate(32'h40, 1'b0, 1'b0);
        doLookup(32'h40, 2'b00, 16'd5, 16'd0);
        doUpdate(32'h40, 1'b1, 1'b0);
        doLookup(32'h40, 2'b01, 16'd6, 16'd0);

        // Same-cycle bypass, then independent indices.
        applyStimulus(1'b1, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 2'b10, 16'd7, 16'd0);
        applyStimulus(1'b1, 1'b1, 32'h84, 1'b1, 32'h80, 1'b1, 1'b0, 2'b01, 16'd8, 16'd0);
        doLookup(32'h80, 2'b11, 16'd9, 16'd0);

        // Aliasing (0x10 and 0x110 share index 4) and idle hold.
        doUpdate(32'h10, 1'b1, 1'b0);
        doUpdate(32'h10, 1'b1, 1'b0);
        doLookup(32'h110, 2'b11, 16'd10, 16'd0);
        doIdle();
        checkOutput("idle_valid", {15'h0, pred_valid}, 16'h0);
        checkOutput("idle_state", {14'h0, pred_state}, 16'h3);
        checkOutput("idle_taken", {15'h0, pred_taken}, 16'h1);

        // Mispredict counting; the UpdValid=0 beat must not count.
        doUpdate(32'h100, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h100, 1'b1, 1'b1, 2'b00, 16'h0, 16'h0);
        doUpdate(32'h100, 1'b0, 1'b1);
        checkOutput("mcnt", mispred_count, 16'd2);
        checkOutput("lcnt", lookup_count, 16'd10);
        checkOutput("small_lcnt_sat", {14'h0, lookup_count2}, 16'd3);
        checkOutput("small_mcnt", {14'h0, mispred_count2}, 16'd2);

        // Reset during an active update and lookup: update is discarded.
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 2'b00, 16'h0, 16'h0);
        checkOutput("midrst_valid", {15'h0, pred_valid}, 16'h0);
        checkOutput("midrst_state", {14'h0, pred_state}, 16'h1);
        checkOutput("midrst_lcnt", lookup_count, 16'h0);
        checkOutput("midrst_mcnt", mispred_count, 16'h0);
        checkOutput("midrst_small_lcnt", {14'h0, lookup_count2}, 16'h0);
        doLookup(32'h40, 2'b01, 16'd1, 16'd0);
        doLookup(32'h10, 2'b01, 16'd2, 16'd0);
        doIdle();

        checkOutput("sb_drained", sb_q.size(), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor_2bit.md
Name: branch_predictor_2bit

Overview:
- Direct-mapped table of 2-bit saturating counters, one per entry, indexed by low PC word-address bits.
- Sits in IF and produces the registered 2-bit prediction state that the next-PC 2-bit 2:1 mux consumes downstream.
- Updated from EX with the resolved branch outcome.
- Also counts lookups and mispredictions for performance measurement.

Parameters:
IDX_BITS, 6, index width; table depth = 2^IDX_BITS entries
CNT_W, 16, width of the lookup and mispredict statistics counters

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset; sampled on rising edge of Clk
LookupValid  input  1  IF stage requests a prediction this cycle
LookupPC  input  32  PC of the fetched instruction
PredState  output  2  registered counter value for the last lookup (feeds the 2-bit mux)
PredTaken  output  1  PredState[1]; registered with PredState
PredValid  output  1  high the cycle after an accepted lookup
UpdValid  input  1  EX resolves a branch this cycle
UpdPC  input  32  PC of the resolving branch
UpdTaken  input  1  actual outcome (1 = taken)
UpdMispredict  input  1  EX detected a wrong prediction for this branch
LookupCount  output  CNT_W  number of accepted lookups since reset
MispredCount  output  CNT_W  number of UpdValid&&UpdMispredict since reset

Behaviour:
- Index = PC[IDX_BITS+1:2] for both lookup and update; PC[1:0] ignored.
- Reset (Reset==0 at rising edge):
  - all table entries = 2'b01 (weakly not-taken)
  - PredState = 2'b01, PredTaken = 0, PredValid = 0
  - LookupCount = 0, MispredCount = 0
  - Reset overrides every other input that cycle.
  - Reset mid-operation discards any in-flight update.
- Lookup latency: 1 cycle.
  - If LookupValid is high at edge N, then after edge N: PredState = entry[idx], PredTaken = entry[idx][1], PredValid = 1.
  - If LookupValid is low, PredValid = 0 and PredState/PredTaken hold their previous values.
- Update takes effect at the edge when UpdValid = 1 (read-modify-write in one cycle):
  - Taken: 00->01->10->11, with 11 saturating at 11.
  - Not taken: 11->10->01->00, with 00 saturating at 00.
  - Entries at other indices are unchanged.
- Simultaneous lookup and update, same index: lookup returns the post-update value (write-first bypass). Both operations complete in that cycle.
- Simultaneous lookup and update, different index: the two operations are independent.
- Statistics:
  - LookupCount increments on each accepted lookup.
  - MispredCount increments when UpdValid && UpdMispredict; UpdMispredict is ignored when UpdValid = 0.
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
- Aliasing: PCs sharing an index share an entry. No tags; this is intended behaviour.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
- Reset then lookup:
  - Reset=0 for 2 cycles, then Reset=1.
  - LookupValid=1, LookupPC=0x0000_0040.
  - Next cycle: PredState=01, PredTaken=0, PredValid=1, LookupCount=1.
- Saturate taken:
  - 4 updates with UpdPC=0x40, UpdTaken=1, then lookup 0x40.
  - PredState=11, PredTaken=1.
  - A 5th taken update followed by lookup still gives 11.
- Saturate not-taken and hysteresis:
  - From 11, apply one not-taken update; lookup gives 10, PredTaken=1.
  - Apply 3 more not-taken updates; lookup gives 00.
  - Apply 1 taken update; lookup gives 01.
- Same-cycle bypass and index independence:
  - Entry 0x80 = 01; drive UpdValid=1, UpdPC=0x80, UpdTaken=1 and LookupValid=1, LookupPC=0x80 in the same cycle.
  - Next cycle PredState=10.
  - Repeat with LookupPC=0x84: lookup gives 01, and entry 0x80 becomes 11.
- Aliasing and idle hold:
  - With IDX_BITS=6, update 0x0000_0010 taken twice, then lookup 0x0000_0110: PredState=11.
  - LookupValid=0 next cycle: PredValid=0, PredState holds 11.
- Counters and mid-operation reset:
  - Drive 3 updates with UpdMispredict=1, one of them with UpdValid=0: MispredCount=2.
  - With CNT_W=2, 5 lookups: LookupCount=3 (saturated).
  - Assert Reset=0 during an active update: entry reads 01 after reset and both counters = 0.
